// File: rtl/dc_hex_ascii_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dc_hex_ascii_stream_pkg
//  Purpose  : Shared ASCII constants and FSM state encoding for the
//             hex-to-ASCII byte streamer.
//  Contents : CHR_0, CHR_A, CHR_X, CHR_CR, CHR_LF, LOWER_OFS, state_e
//  Revision : 1.0 - initial release
// ============================================================================
package dc_hex_ascii_stream_pkg;

  localparam logic [7:0] CHR_0     = 8'h30;
  localparam logic [7:0] CHR_A     = 8'h41;
  localparam logic [7:0] CHR_X     = 8'h78;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] LOWER_OFS = 8'h20;

  // The state names the kind of byte currently presented on OUT_CHAR.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PFX0  = 3'd1,
    ST_PFX1  = 3'd2,
    ST_DIGIT = 3'd3,
    ST_CR    = 3'd4,
    ST_LF    = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dc_hex_ascii_stream_nibble.sv
`default_nettype none
// ============================================================================
//  Module   : hex_nibble_ascii
//  Purpose  : Combinational 4-bit nibble to ASCII hex digit encoder.
//  Ports    : nibble_i [3:0] - value to encode
//             lower_i        - 1 = 'a'-'f', 0 = 'A'-'F'
//             char_o   [7:0] - ASCII character
//  Revision : 1.0 - initial release
// ============================================================================
module hex_nibble_ascii
  import dc_hex_ascii_stream_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       lower_i,
  output logic [7:0] char_o
);

  always_comb begin
    char_o = CHR_0 + {4'h0, nibble_i};
    if (nibble_i > 4'd9) begin
      char_o = CHR_A + {4'h0, nibble_i} - 8'd10;
      if (lower_i) begin
        char_o = char_o | LOWER_OFS;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dc_hex_ascii_stream.sv
`default_nettype none
// ============================================================================
//  Module   : dc_hex_ascii_stream
//  Purpose  : Serialises a DATA_W-bit word into ASCII hex bytes:
//             optional "0x", digits MS nibble first, optional CR LF.
//  Ports    : CLK, RST (async, active high)
//             IN_DATA/IN_LOWER/IN_SUPPRESS/IN_VALID/IN_READY - word input
//             OUT_CHAR/OUT_VALID/OUT_READY/OUT_LAST          - byte output
//             BUSY - a word is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module dc_hex_ascii_stream
  import dc_hex_ascii_stream_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PREFIX_EN = 1,
  parameter int TERM_EN   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_LOWER,
  input  logic              IN_SUPPRESS,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [7:0]        OUT_CHAR,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OUT_LAST,
  output logic              BUSY
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((DATA_W % 4 != 0) || (DATA_W < 4)) begin : g_bad_width
    $error("dc_hex_ascii_stream: DATA_W must be a multiple of 4 and >= 4");
  end

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                lower_q, lower_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          char_q, char_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;

  logic [CNT_W-1:0]    w_top_nz;
  logic [CNT_W-1:0]    w_start;
  logic [CNT_W-1:0]    w_pad;
  logic [DATA_W-1:0]   w_align;
  logic [DATA_W-1:0]   w_shift;
  logic [3:0]          w_enc_nib;
  logic                w_enc_low;
  logic [7:0]          w_enc;
  logic                w_adv;

  // Leading-zero search: index of the highest nonzero nibble (0 if all zero,
  // which yields the single '0' digit for an all-zero suppressed word).
  always_comb begin
    w_top_nz = '0;
    for (int i = 0; i < NIB; i++) begin
      if (IN_DATA[4*i +: 4] != 4'h0) begin
        w_top_nz = CNT_W'(i);
      end
    end
  end

  assign w_start = IN_SUPPRESS ? w_top_nz : CNT_W'(NIB - 1);
  assign w_pad   = CNT_W'(NIB - 1) - w_start;

  // The word is left-aligned at accept so the digit being shown is always
  // the top nibble of the shift register.
  assign w_align = IN_DATA << {w_pad, 2'b00};
  assign w_shift = data_q << 4;

  // Encoder input: the first digit at accept, the next digit while stepping
  // through DIGIT, otherwise the current top nibble (leaving PFX1).
  always_comb begin
    w_enc_nib = data_q[DATA_W-1 -: 4];
    w_enc_low = lower_q;
    if (state_q == ST_IDLE) begin
      w_enc_nib = w_align[DATA_W-1 -: 4];
      w_enc_low = IN_LOWER;
    end else if (state_q == ST_DIGIT) begin
      w_enc_nib = w_shift[DATA_W-1 -: 4];
    end
  end

  hex_nibble_ascii u_enc (
    .nibble_i (w_enc_nib),
    .lower_i  (w_enc_low),
    .char_o   (w_enc)
  );

  assign w_adv = valid_q && OUT_READY;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    lower_d = lower_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          data_d  = w_align;
          lower_d = IN_LOWER;
          cnt_d   = w_start;
          valid_d = 1'b1;
          if (PREFIX_EN != 0) begin
            state_d = ST_PFX0;
            char_d  = CHR_0;
            last_d  = 1'b0;
          end else begin
            state_d = ST_DIGIT;
            char_d  = w_enc;
            last_d  = (w_start == '0) && (TERM_EN == 0);
          end
        end
      end
      ST_PFX0: begin
        if (w_adv) begin
          state_d = ST_PFX1;
          char_d  = CHR_X;
        end
      end
      ST_PFX1: begin
        if (w_adv) begin
          state_d = ST_DIGIT;
          char_d  = w_enc;
          last_d  = (cnt_q == '0) && (TERM_EN == 0);
        end
      end
      ST_DIGIT: begin
        if (w_adv) begin
          if (cnt_q != '0) begin
            data_d = w_shift;
            cnt_d  = cnt_q - CNT_W'(1);
            char_d = w_enc;
            last_d = (cnt_q == CNT_W'(1)) && (TERM_EN == 0);
          end else if (TERM_EN != 0) begin
            state_d = ST_CR;
            char_d  = CHR_CR;
            last_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
        end
      end
      ST_CR: begin
        if (w_adv) begin
          state_d = ST_LF;
          char_d  = CHR_LF;
          last_d  = 1'b1;
        end
      end
      ST_LF: begin
        if (w_adv) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      lower_q <= 1'b0;
      cnt_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      lower_q <= lower_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign OUT_CHAR  = char_q;
  assign OUT_VALID = valid_q;
  assign OUT_LAST  = last_q;

endmodule
`default_nettype wire

// File: tb/tb_dc_hex_ascii_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dc_hex_ascii_stream
//  Purpose  : Directed self-checking bench for dc_hex_ascii_stream.
//             u_dut_a: DATA_W=16 with prefix and terminator.
//             u_dut_b: DATA_W=16, bare digits (back-to-back words).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dc_hex_ascii_stream;

  logic        clk;
  logic        rst;

  logic [15:0] a_data;
  logic        a_lower, a_sup, a_valid, a_ready;
  logic [7:0]  a_char;
  logic        a_ovalid, a_oready, a_last, a_busy;

  logic [15:0] b_data;
  logic        b_lower, b_sup, b_valid, b_ready;
  logic [7:0]  b_char;
  logic        b_ovalid, b_oready, b_last, b_busy;

  int checks = 0;
  int errors = 0;

  dc_hex_ascii_stream #(.DATA_W(16), .PREFIX_EN(1), .TERM_EN(1)) u_dut_a (
    .CLK(clk), .RST(rst),
    .IN_DATA(a_data), .IN_LOWER(a_lower), .IN_SUPPRESS(a_sup),
    .IN_VALID(a_valid), .IN_READY(a_ready),
    .OUT_CHAR(a_char), .OUT_VALID(a_ovalid), .OUT_READY(a_oready),
    .OUT_LAST(a_last), .BUSY(a_busy)
  );

  dc_hex_ascii_stream #(.DATA_W(16), .PREFIX_EN(0), .TERM_EN(0)) u_dut_b (
    .CLK(clk), .RST(rst),
    .IN_DATA(b_data), .IN_LOWER(b_lower), .IN_SUPPRESS(b_sup),
    .IN_VALID(b_valid), .IN_READY(b_ready),
    .OUT_CHAR(b_char), .OUT_VALID(b_ovalid), .OUT_READY(b_oready),
    .OUT_LAST(b_last), .BUSY(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One word through u_dut_a. seq holds the expected bytes left-aligned.
  // bp=1 randomises OUT_READY and holds it low 5 cycles on byte hold_idx.
  task automatic run_word(input logic [15:0] d, input logic low, input logic sup,
                          input int n, input logic [63:0] seq,
                          input bit bp, input int hold_idx);
    int   idx;
    int   cyc;
    int   hold_cnt;
    logic rdy;
    @(negedge clk);
    chk("in_ready_idle", a_ready, 1);
    a_data   = d;
    a_lower  = low;
    a_sup    = sup;
    a_valid  = 1'b1;
    a_oready = bp ? 1'b0 : 1'b1;
    @(negedge clk);
    // Input changes after accept must not leak into the word in flight.
    a_valid = 1'b0;
    a_data  = 16'hFFFF;
    a_lower = ~low;
    a_sup   = ~sup;
    idx = 0;
    cyc = 0;
    hold_cnt = 0;
    while (idx < n && cyc < 200) begin
      chk("out_valid", a_ovalid, 1);
      chk("out_char", a_char, seq[63-8*idx -: 8]);
      chk("out_last", a_last, (idx == n - 1));
      chk("in_ready_busy", a_ready, 0);
      if (!bp) begin
        rdy = 1'b1;
      end else if (idx == hold_idx && hold_cnt < 5) begin
        rdy = 1'b0;
        hold_cnt++;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      a_oready = rdy;
      if (a_ovalid && rdy) idx++;
      @(negedge clk);
      cyc++;
    end
    chk("byte_count", idx, n);
    if (!bp) chk("consecutive_cycles", cyc, n);
    if (bp) chk("hold_cycles", hold_cnt, 5);
    chk("end_valid", a_ovalid, 0);
    chk("end_last", a_last, 0);
    chk("end_in_ready", a_ready, 1);
    chk("end_busy", a_busy, 0);
    a_oready = 1'b1;
  endtask

  initial begin
    logic [8:0]  ev;
    logic [8:0]  el;
    logic [8:0]  er;
    logic [71:0] ec;

    rst = 1'b1;
    a_data = '0; a_lower = 0; a_sup = 0; a_valid = 0; a_oready = 1'b1;
    b_data = '0; b_lower = 0; b_sup = 0; b_valid = 0; b_oready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state (OUT_READY high while idle has no effect)
    chk("rst_out_valid", a_ovalid, 0);
    chk("rst_out_char", a_char, 8'h00);
    chk("rst_out_last", a_last, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_in_ready", a_ready, 1);
    chk("rst_b_out_valid", b_ovalid, 0);
    chk("rst_b_in_ready", b_ready, 1);

    // Basic conversions
    run_word(16'h1A2F, 0, 0, 8, 64'h3078_3141_3246_0D0A, 0, 0);
    run_word(16'hBEEF, 1, 0, 8, 64'h3078_6265_6566_0D0A, 0, 0);
    run_word(16'h00C0, 0, 1, 6, 64'h3078_4330_0D0A_0000, 0, 0);
    run_word(16'h0000, 0, 1, 5, 64'h3078_300D_0A00_0000, 0, 0);
    run_word(16'h0000, 0, 0, 8, 64'h3078_3030_3030_0D0A, 0, 0);

    // Backpressure: hold on the 'A' byte (index 3)
    run_word(16'h1A2F, 0, 0, 8, 64'h3078_3141_3246_0D0A, 1, 3);

    // Asynchronous reset during the third digit
    @(negedge clk);
    a_data = 16'h1A2F; a_lower = 0; a_sup = 0; a_valid = 1'b1; a_oready = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_char", a_char, 8'h32);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", a_ovalid, 0);
    chk("arst_in_ready", a_ready, 1);
    chk("arst_out_char", a_char, 8'h00);
    chk("arst_out_last", a_last, 0);
    chk("arst_busy", a_busy, 0);
    #1 rst = 1'b0;
    run_word(16'h7F05, 1, 0, 8, 64'h3078_3766_3035_0D0A, 0, 0);

    // Back-to-back words on the bare-digit instance, IN_VALID held high
    ev = 9'b1_1110_1110;  // n1..n9, MSB = n1
    el = 9'b0_0010_0010;
    er = 9'b0_0001_0001;
    ec = 72'h30_41_32_46_00_62_65_65_00;
    @(negedge clk);
    b_data = 16'h0A2F; b_lower = 0; b_sup = 0; b_valid = 1'b1; b_oready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("b2b_out_valid", b_ovalid, ev[9-k]);
      chk("b2b_out_last", b_last, el[9-k]);
      chk("b2b_in_ready", b_ready, er[9-k]);
      if (ev[9-k]) chk("b2b_out_char", b_char, ec[71-8*(k-1) -: 8]);
      if (k == 1) begin
        b_data = 16'h0BEE; b_lower = 1'b1; b_sup = 1'b1;
      end
      if (k == 6) b_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
